// File: rtl/scene_config_controller_pkg.sv
// Shared scene types: sphere word packing, scene size, SPI sync word and controller states.
package scene_config_controller_pkg;

   typedef struct packed {
      logic signed [15:0] x;
      logic signed [15:0] y;
      logic signed [15:0] z;
      logic        [7:0]  r;
      logic        [7:0]  col;
   } sphere_t;

   localparam int          SCENE_N_SPHERES = 4;
   localparam logic [63:0] SCENE_SYNC_WORD = 64'hFFFF_FFFF_FFFF_FFFF;
   localparam sphere_t     SCENE_DEFAULT_SPHERE = '{x: -16'sd100, y: -16'sd200, z: 16'sd400,
                                                    r: 8'd6, col: 8'd0};

   typedef enum logic [1:0] {
      ST_LOADING = 2'd0,
      ST_PENDING = 2'd1,
      ST_SWAP    = 2'd2
   } scene_state_t;

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/scene_config_controller_bank.sv
// Double-buffered sphere storage: shadow write port, registered active read port, atomic bank toggle.
module scene_config_controller_bank
   import scene_config_controller_pkg::*;
#(
   parameter int      N_SPHERES      = SCENE_N_SPHERES,
   parameter sphere_t DEFAULT_SPHERE = SCENE_DEFAULT_SPHERE,
   parameter int      IW             = idx_width(SCENE_N_SPHERES)
)(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          wr_en,
   input  logic [IW-1:0] wr_idx,
   input  logic [63:0]   wr_data,
   input  logic          swap,
   input  logic          rd_en,
   input  logic [IW-1:0] rd_idx,
   input  logic [3:0]    n_active,
   output logic [63:0]   rd_sphere,
   output logic          rd_valid
);

   logic              bank_sel;
   logic [63:0]       bank [2][N_SPHERES];
   logic [63:0]       rd_sphere_p1;
   logic              vld_p1;

   // Toggling the select makes the old active bank the new shadow, which is cleared in the same edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bank_sel <= 1'b0;
         for (int b = 0; b < 2; b++)
            for (int i = 0; i < N_SPHERES; i++)
               bank[b][i] <= '0;
         bank[0][0] <= DEFAULT_SPHERE;
      end else if (swap) begin
         bank_sel <= ~bank_sel;
         for (int i = 0; i < N_SPHERES; i++)
            bank[bank_sel][i] <= '0;
      end else if (wr_en) begin
         bank[~bank_sel][wr_idx] <= wr_data;
      end
   end

   // Read stage p1: uses the pre-swap select, so a read on the swap cycle still sees the old scene.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_sphere_p1 <= '0;
         vld_p1       <= 1'b0;
      end else begin
         vld_p1 <= rd_en;
         if (rd_en)
            rd_sphere_p1 <= (4'(rd_idx) < n_active) ? bank[bank_sel][rd_idx] : 64'h0;
      end
   end

   assign rd_sphere = rd_sphere_p1;
   assign rd_valid  = vld_p1;

endmodule

// File: rtl/scene_config_controller.sv
// Scene loader: gathers SPI sphere words into the shadow bank and swaps banks only on a frame boundary.
module scene_config_controller
   import scene_config_controller_pkg::*;
#(
   parameter int          N_SPHERES      = SCENE_N_SPHERES,
   parameter logic [63:0] SYNC_WORD      = SCENE_SYNC_WORD,
   parameter sphere_t     DEFAULT_SPHERE = SCENE_DEFAULT_SPHERE,
   localparam int         IW             = idx_width(N_SPHERES)
)(
   input  logic          CLK100MHZ,
   input  logic          ck_rst_,
   input  logic          recv_dv,
   input  logic [63:0]   recv_64bit,
   output logic          recv_interrupt,
   input  logic          frame_start,
   input  logic          rd_en,
   input  logic [IW-1:0] rd_idx,
   output logic [63:0]   rd_sphere,
   output logic          rd_valid,
   output logic [3:0]    n_active,
   output logic          swap_pulse,
   output logic          overrun
);

   scene_state_t  state, state_nxt;
   logic [IW-1:0] wr_idx;
   logic          wr_en;
   logic          is_sync;

   assign is_sync = (recv_64bit == SYNC_WORD);

   always_ff @(posedge CLK100MHZ or negedge ck_rst_) begin
      if (!ck_rst_) begin
         state    <= ST_LOADING;
         wr_idx   <= '0;
         overrun  <= 1'b0;
         n_active <= 4'd1;
      end else begin
         state <= state_nxt;
         if (swap_pulse)
            wr_idx <= '0;
         else if (state == ST_LOADING && recv_dv)
            wr_idx <= is_sync ? '0 : wr_idx + IW'(1);
         if (recv_dv && !recv_interrupt)
            overrun <= 1'b1;
         if (swap_pulse)
            n_active <= 4'(N_SPHERES);
      end
   end

   // frame_start is deliberately ignored while loading so a partial scene is never shown.
   always_comb begin
      state_nxt      = state;
      recv_interrupt = 1'b0;
      swap_pulse     = 1'b0;
      wr_en          = 1'b0;
      case (state)
         ST_LOADING: begin
            recv_interrupt = 1'b1;
            wr_en          = recv_dv && !is_sync;
            if (wr_en && wr_idx == IW'(N_SPHERES - 1))
               state_nxt = ST_PENDING;
         end
         ST_PENDING: begin
            if (frame_start)
               state_nxt = ST_SWAP;
         end
         ST_SWAP: begin
            swap_pulse = 1'b1;
            state_nxt  = ST_LOADING;
         end
         default: state_nxt = ST_LOADING;
      endcase
   end

   scene_config_controller_bank #(
      .N_SPHERES      (N_SPHERES),
      .DEFAULT_SPHERE (DEFAULT_SPHERE),
      .IW             (IW)
   ) u_scene_bank (
      .clk       (CLK100MHZ),
      .rst_n     (ck_rst_),
      .wr_en     (wr_en),
      .wr_idx    (wr_idx),
      .wr_data   (recv_64bit),
      .swap      (swap_pulse),
      .rd_en     (rd_en),
      .rd_idx    (rd_idx),
      .n_active  (n_active),
      .rd_sphere (rd_sphere),
      .rd_valid  (rd_valid)
   );

endmodule
